// File: rtl/synth_pkg.sv
// ============================================================================
// Module   : synth_pkg
// Brief    : Shared synth register-file widths, scope encodings and SPI
//            writer state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package synth_pkg;

    localparam int REG_NUMBER_WIDTH = 16;
    localparam int REG_VALUE_WIDTH  = 8;

    // Top two bits of a register number select the addressed scope.
    localparam logic [1:0] SCOPE_VOICE_OPERATOR = 2'b11;
    localparam logic [1:0] SCOPE_VOICE          = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/synchronizer.sv
// ============================================================================
// Module   : synchronizer
// Brief    : Multi-flop synchronizer for one asynchronous input bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module synchronizer #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic [STAGES-1:0] stages_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            stages_q <= {STAGES{RESET_VALUE}};
        end else begin
            stages_q <= {stages_q[STAGES-2:0], i_Async};
        end
    end

    assign o_Sync = stages_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_register_writer.sv
// ============================================================================
// Module   : spi_register_writer
// Brief    : SPI mode-0 slave turning 24-bit frames into register write strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_register_writer
    import synth_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 24
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_SPI_SCK,
    input  logic                        i_SPI_CS_N,
    input  logic                        i_SPI_MOSI,
    output logic                        o_RegisterWriteEnable,
    output logic [REG_NUMBER_WIDTH-1:0] o_RegisterWriteNumber,
    output logic [REG_VALUE_WIDTH-1:0]  o_RegisterWriteValue,
    output logic                        o_FrameError
);

    localparam logic [4:0] c_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] c_LAST = 5'(FRAME_BITS - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("SYNC_STAGES must be at least 2");
        end
        if (FRAME_BITS != REG_NUMBER_WIDTH + REG_VALUE_WIDTH) begin : g_bad_frame_bits
            $error("FRAME_BITS must equal register number plus value width");
        end
    endgenerate

    logic w_sck;
    logic w_cs_n;
    logic w_mosi;

    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SPI_SCK),  .o_Sync(w_sck)
    );
    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs_n (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SPI_CS_N), .o_Sync(w_cs_n)
    );
    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SPI_MOSI), .o_Sync(w_mosi)
    );

    spi_state_t                 state_q;
    spi_state_t                 state_d;
    logic                       sck_prev_q;
    logic [4:0]                 count_q;
    logic [FRAME_BITS-1:0]      shift_q;
    logic                       we_q;
    logic [REG_NUMBER_WIDTH-1:0] number_q;
    logic [REG_VALUE_WIDTH-1:0]  value_q;
    logic                       err_q;
    logic [SYNC_STAGES-1:0]     settle_q;
    logic                       armed_q;
    logic                       w_sck_rise;
    logic                       w_shift_en;
    logic                       w_abort;

    assign w_sck_rise = w_sck & ~sck_prev_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shifting only starts once CS has been seen high after reset, so a
    // frame interrupted by reset is never resumed mid-way.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (armed_q && !w_cs_n) state_d = ST_SHIFT;
            ST_SHIFT: if (w_cs_n)             state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // A final edge coinciding with CS release still completes the frame.
    always_comb begin
        w_shift_en = 1'b0;
        w_abort    = 1'b0;
        if (state_q == ST_SHIFT) begin
            w_shift_en = w_sck_rise && (!w_cs_n || count_q == c_LAST);
            w_abort    = w_cs_n && !w_shift_en && count_q != 5'd0 && count_q != c_FULL;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sck_prev_q <= 1'b0;
            count_q    <= 5'd0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            number_q   <= '0;
            value_q    <= '0;
            err_q      <= 1'b0;
            settle_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            sck_prev_q <= w_sck;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            settle_q   <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            if (settle_q[SYNC_STAGES-1] && w_cs_n) begin
                armed_q <= 1'b1;
            end
            if (count_q == c_FULL) begin
                we_q     <= 1'b1;
                number_q <= shift_q[FRAME_BITS-1:REG_VALUE_WIDTH];
                value_q  <= shift_q[REG_VALUE_WIDTH-1:0];
                count_q  <= 5'd0;
            end else if (w_shift_en) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], w_mosi};
                count_q <= count_q + 5'd1;
            end else if (w_abort) begin
                err_q   <= 1'b1;
                count_q <= 5'd0;
            end
        end
    end

    assign o_RegisterWriteEnable = we_q;
    assign o_RegisterWriteNumber = number_q;
    assign o_RegisterWriteValue  = value_q;
    assign o_FrameError          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_register_writer.sv
// ============================================================================
// Module   : tb_spi_register_writer
// Brief    : Directed self-checking bench for spi_register_writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_register_writer;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_SPI_SCK = 1'b0;
    logic        i_SPI_CS_N = 1'b1;
    logic        i_SPI_MOSI = 1'b0;
    logic        o_RegisterWriteEnable;
    logic [15:0] o_RegisterWriteNumber;
    logic [7:0]  o_RegisterWriteValue;
    logic        o_FrameError;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int err_pulses = 0;
    logic [15:0] s_num[$];
    logic [7:0]  s_val[$];
    int          s_cyc[$];

    spi_register_writer #(.SYNC_STAGES(2), .FRAME_BITS(24)) dut (
        .i_Clock               (i_Clock),
        .i_Reset               (i_Reset),
        .i_SPI_SCK             (i_SPI_SCK),
        .i_SPI_CS_N            (i_SPI_CS_N),
        .i_SPI_MOSI            (i_SPI_MOSI),
        .o_RegisterWriteEnable (o_RegisterWriteEnable),
        .o_RegisterWriteNumber (o_RegisterWriteNumber),
        .o_RegisterWriteValue  (o_RegisterWriteValue),
        .o_FrameError          (o_FrameError)
    );

    always #5 i_Clock = ~i_Clock;

    always @(posedge i_Clock) cyc <= cyc + 1;

    always @(negedge i_Clock) begin
        if (o_RegisterWriteEnable) begin
            s_num.push_back(o_RegisterWriteNumber);
            s_val.push_back(o_RegisterWriteValue);
            s_cyc.push_back(cyc);
        end
        if (o_FrameError) err_pulses++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    // SCK = clk/8: four clocks low with data set up, four clocks high.
    task automatic send_bit(input logic b);
        i_SPI_MOSI = b;
        wait_clk(4);
        i_SPI_SCK = 1'b1;
        last_rise_cyc = cyc;
        wait_clk(4);
        i_SPI_SCK = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(v[i]);
    endtask

    task automatic cs_low();
        i_SPI_CS_N = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_high();
        wait_clk(4);
        i_SPI_CS_N = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_reset();
        wait_clk(3);
        checks++; if (o_RegisterWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", o_RegisterWriteEnable); end
        checks++; if (o_RegisterWriteNumber !== 16'h0000) begin errors++; $display("FAIL reset_num: got %h expected 0000", o_RegisterWriteNumber); end
        checks++; if (o_RegisterWriteValue !== 8'h00) begin errors++; $display("FAIL reset_val: got %h expected 00", o_RegisterWriteValue); end
        checks++; if (o_FrameError !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_FrameError); end
        i_Reset = 1'b0;
        wait_clk(6);
        checks++; if (s_num.size() !== 0 || err_pulses !== 0) begin errors++; $display("FAIL reset_quiet: got strobes %0d errs %0d expected 0 0", s_num.size(), err_pulses); end
    endtask

    task automatic test_single_frame();
        int n0 = s_num.size();
        int e0 = err_pulses;
        cs_low();
        send_bits(24'hC00CA5, 24);
        cs_high();
        checks++; if (s_num.size() - n0 !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", s_num.size() - n0); end
        checks++; if (s_num.size() <= n0 || s_num[n0] !== 16'hC00C) begin errors++; $display("FAIL single_num: got %h expected c00c", (s_num.size() > n0) ? s_num[n0] : 16'hxxxx); end
        checks++; if (s_val.size() <= n0 || s_val[n0] !== 8'hA5) begin errors++; $display("FAIL single_val: got %h expected a5", (s_val.size() > n0) ? s_val[n0] : 8'hxx); end
        checks++; if (s_cyc.size() <= n0 || s_cyc[n0] - last_rise_cyc !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", (s_cyc.size() > n0) ? s_cyc[n0] - last_rise_cyc : -1); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", err_pulses - e0); end
        wait_clk(10);
        checks++; if (o_RegisterWriteNumber !== 16'hC00C || o_RegisterWriteValue !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h/%h expected c00c/a5", o_RegisterWriteNumber, o_RegisterWriteValue); end
    endtask

    task automatic test_back_to_back();
        int n0 = s_num.size();
        int e0 = err_pulses;
        cs_low();
        send_bits(24'hC00112, 24);
        send_bits(24'h800001, 24);
        cs_high();
        checks++; if (s_num.size() - n0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", s_num.size() - n0); end
        checks++; if (s_num.size() < n0 + 2 || s_num[n0] !== 16'hC001 || s_val[n0] !== 8'h12) begin errors++; $display("FAIL b2b_first: got %h/%h expected c001/12", (s_num.size() > n0) ? s_num[n0] : 16'hxxxx, (s_val.size() > n0) ? s_val[n0] : 8'hxx); end
        checks++; if (s_num.size() < n0 + 2 || s_num[n0+1] !== 16'h8000 || s_val[n0+1] !== 8'h01) begin errors++; $display("FAIL b2b_second: got %h/%h expected 8000/01", (s_num.size() > n0 + 1) ? s_num[n0+1] : 16'hxxxx, (s_val.size() > n0 + 1) ? s_val[n0+1] : 8'hxx); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", err_pulses - e0); end
    endtask

    task automatic test_partial_frame();
        int n0 = s_num.size();
        int e0 = err_pulses;
        cs_low();
        send_bits(24'hABCDEF, 10);
        cs_high();
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL partial_err: got %0d expected 1", err_pulses - e0); end
        checks++; if (s_num.size() - n0 !== 0) begin errors++; $display("FAIL partial_strobe: got %0d expected 0", s_num.size() - n0); end
        cs_low();
        send_bits(24'hC0007F, 24);
        cs_high();
        checks++; if (s_num.size() - n0 !== 1 || s_num[n0] !== 16'hC000 || s_val[n0] !== 8'h7F) begin errors++; $display("FAIL partial_next: got %0d strobes %h/%h expected 1 c000/7f", s_num.size() - n0, (s_num.size() > n0) ? s_num[n0] : 16'hxxxx, (s_val.size() > n0) ? s_val[n0] : 8'hxx); end
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL partial_next_err: got %0d expected 1", err_pulses - e0); end
    endtask

    task automatic test_idle_sck();
        int n0 = s_num.size();
        int e0 = err_pulses;
        for (int i = 0; i < 30; i++) begin
            i_SPI_MOSI = i[0];
            i_SPI_SCK = 1'b1;
            wait_clk(4);
            i_SPI_SCK = 1'b0;
            wait_clk(4);
        end
        wait_clk(8);
        checks++; if (s_num.size() - n0 !== 0 || err_pulses - e0 !== 0) begin errors++; $display("FAIL idle_sck: got strobes %0d errs %0d expected 0 0", s_num.size() - n0, err_pulses - e0); end
        checks++; if (dut.count_q !== 5'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", dut.count_q); end
    endtask

    task automatic test_reset_midframe();
        int n0 = s_num.size();
        int e0 = err_pulses;
        cs_low();
        send_bits(24'h123456, 12);
        i_Reset = 1'b1;
        wait_clk(1);
        i_Reset = 1'b0;
        // CS stays low: the remaining bits must not start a new frame.
        send_bits(24'h789ABC, 12);
        wait_clk(8);
        checks++; if (s_num.size() - n0 !== 0 || err_pulses - e0 !== 0) begin errors++; $display("FAIL rst_abort: got strobes %0d errs %0d expected 0 0", s_num.size() - n0, err_pulses - e0); end
        cs_high();
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL rst_cs_release: got %0d expected 0", err_pulses - e0); end
        cs_low();
        send_bits(24'hC0FF01, 24);
        cs_high();
        checks++; if (s_num.size() - n0 !== 1 || s_num[n0] !== 16'hC0FF || s_val[n0] !== 8'h01) begin errors++; $display("FAIL rst_next: got %0d strobes %h/%h expected 1 c0ff/01", s_num.size() - n0, (s_num.size() > n0) ? s_num[n0] : 16'hxxxx, (s_val.size() > n0) ? s_val[n0] : 8'hxx); end
    endtask

    task automatic test_cs_with_last_edge();
        int n0 = s_num.size();
        int e0 = err_pulses;
        logic [23:0] frame = 24'hC0AB5A;
        cs_low();
        send_bits(frame, 23);
        i_SPI_MOSI = frame[0];
        wait_clk(4);
        i_SPI_SCK = 1'b1;
        i_SPI_CS_N = 1'b1;
        last_rise_cyc = cyc;
        wait_clk(4);
        i_SPI_SCK = 1'b0;
        wait_clk(8);
        checks++; if (s_num.size() - n0 !== 1 || s_num[n0] !== 16'hC0AB || s_val[n0] !== 8'h5A) begin errors++; $display("FAIL cs_last_strobe: got %0d strobes %h/%h expected 1 c0ab/5a", s_num.size() - n0, (s_num.size() > n0) ? s_num[n0] : 16'hxxxx, (s_val.size() > n0) ? s_val[n0] : 8'hxx); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL cs_last_err: got %0d expected 0", err_pulses - e0); end
        checks++; if (dut.state_q !== 1'b0) begin errors++; $display("FAIL cs_last_state: got %b expected idle 0", dut.state_q); end
    endtask

    initial begin
        @(negedge i_Clock);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_partial_frame();
        test_idle_sck();
        test_reset_midframe();
        test_cs_with_last_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_register_writer.md
SPI_REGISTER_WRITER -- requirements
Module: spi_register_writer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop stages on each SPI input, minimum 2.
REQ-002 SHALL have parameter FRAME_BITS, default 24, meaning bits per write frame: 16-bit register number followed by 8-bit value; this parameter is fixed.
REQ-003 SHALL have port i_Clock, input, 1 bit: the system clock.
REQ-004 SHALL have port i_Reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_SPI_SCK, input, 1 bit: the asynchronous SPI clock, mode 0 (idle low, sample on rising edge).
REQ-006 SHALL have port i_SPI_CS_N, input, 1 bit: the asynchronous chip select, active-low.
REQ-007 SHALL have port i_SPI_MOSI, input, 1 bit: asynchronous serial data, MSB first.
REQ-008 SHALL have port o_RegisterWriteEnable, output, 1 bit: a one-cycle write strobe to the synth register file.
REQ-009 SHALL have port o_RegisterWriteNumber, output, 16 bits: the register number, valid while the strobe is high.
REQ-010 SHALL have port o_RegisterWriteValue, output, 8 bits: the register value, valid while the strobe is high.
REQ-011 SHALL have port o_FrameError, output, 1 bit: a one-cycle pulse when a partial frame is discarded.

Function
REQ-012 SHALL pass SCK, CS_N and MOSI through SYNC_STAGES-deep synchronizers before any use; raw pins SHALL NOT feed logic.
REQ-013 SHALL detect an SCK rising edge in cycle k when the synchronized SCK is 1 and its registered previous value is 0.
REQ-014 SHALL require the i_Clock frequency to be at least 4x the SCK frequency; behaviour below this ratio is undefined.
REQ-015 SHALL implement states IDLE and SHIFT.
REQ-016 SHALL move from IDLE to SHIFT when synchronized CS_N is low.
REQ-017 SHALL move from SHIFT to IDLE when synchronized CS_N is high.
REQ-018 SHALL, on each detected rising edge in SHIFT, shift synchronized MOSI into the LSB of a 24-bit shift register and increment a 5-bit bit counter.
REQ-019 SHALL, when the edge brings the bit counter to 24, in the next cycle: assert o_RegisterWriteEnable for exactly 1 cycle; drive Number = shift[23:8] and Value = shift[7:0]; clear the counter to 0.
REQ-020 SHALL hold Number and Value stable after the strobe until the next strobe.
REQ-021 SHALL accept any number of back-to-back frames within one CS assertion, each producing exactly one strobe.
REQ-022 SHALL, if CS_N deasserts with the bit counter at 1..23, discard the partial frame, clear the counter, pulse o_FrameError for 1 cycle, and produce no strobe.
REQ-023 SHALL, if CS_N deasserts with the counter at 0, return to IDLE with no error pulse.
REQ-024 SHALL ignore SCK edges in IDLE, including edges in the same cycle that CS_N is seen high.
REQ-025 SHALL, when a CS deassertion and the 24th edge are detected in the same cycle, complete the frame (strobe, no error) and then enter IDLE.
REQ-026 SHALL have a latency from the 24th SCK rising edge at the pin to the strobe of SYNC_STAGES+2 i_Clock cycles.

Reset
REQ-027 SHALL, during reset, set state IDLE, counter 0, shift register 0, Enable 0, Number 0x0000, Value 0x00, FrameError 0, and all synchronizer stages to their idle values (SCK 0, CS_N 1, MOSI 0).
REQ-028 SHALL, on reset asserted mid-frame, discard the frame with no strobe and no error pulse; after reset, a fresh CS falling edge is required before shifting resumes.

Structure
REQ-029 SHALL take REG_NUMBER_WIDTH (16), REG_VALUE_WIDTH (8) and the scope-field encodings (11 voice-operator, 10 voice) from the shared package synth_pkg; this block does not decode scope.
REQ-030 SHALL instantiate the synchronizer as a sub-module named synchronizer (parameters STAGES and RESET_VALUE), three instances.

Verification
REQ-031 SHALL be verified by sending one frame 0xC00CA5 at SCK = clk/8 -> one strobe, Number 0xC00C, Value 0xA5, at 4 cycles after the 24th edge.
REQ-032 SHALL be verified by sending frames 0xC00112 then 0x800001 in one CS -> two strobes, (0xC001,0x12) then (0x8000,0x01), with no error.
REQ-033 SHALL be verified by deasserting CS after 10 bits, then sending a full frame 0xC0007F -> one FrameError pulse and no strobe, then one strobe (0xC000,0x7F).
REQ-034 SHALL be verified by toggling SCK 30 times with CS_N high -> no strobe, no error, counter stays 0.
REQ-035 SHALL be verified by asserting reset for 1 cycle after 12 bits, then CS low and a frame 0xC0FF01 -> no strobe or error from the aborted frame, then one strobe (0xC0FF,0x01).
REQ-036 SHALL be verified by deasserting CS in the same synchronized cycle as the 24th edge -> one strobe and no FrameError.
